timing_nco: RTL

TIMING_NCO -- requirements
Module: timing_nco

---
 rtl/msk_timing_pkg.sv | 19 +
 rtl/timing_nco_slen.sv | 55 +++++
 rtl/timing_nco.sv | 129 ++++++++++++
 3 files changed

// File: rtl/msk_timing_pkg.sv
// Shared types and width helpers for the symbol-timing NCO.
package msk_timing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } nco_state_t;

  // Total phase accumulator width: integer sample index plus fraction.
  function automatic int phase_width(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction

  // Width needed to hold a symbol length of up to 2*osf+1 clocks.
  function automatic int slen_width(input int osf);
    return $clog2(2 * osf + 1);
  endfunction

endpackage

// File: rtl/timing_nco_slen.sv
// Measures clocks between phase wraps and flags short/long symbols.
module timing_nco_slen
  import msk_timing_pkg::*;
#(
  parameter int OSF    = 20,
  parameter int SLEN_W = slen_width(OSF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wrap,
  output logic [SLEN_W-1:0] sym_len_o,
  output logic              early_o,
  output logic              late_o
);

  localparam logic [SLEN_W-1:0] CNT_MAX = SLEN_W'(2 * OSF);
  localparam logic [SLEN_W-1:0] OSF_LEN = SLEN_W'(OSF);

  logic [SLEN_W-1:0] cnt;
  logic [SLEN_W-1:0] len;
  logic              first_q;

  assign len = cnt + SLEN_W'(1);

  // Count clocks since the last wrap; the first wrap after a restart has no
  // meaningful reference, so its early/late verdict is withheld.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      first_q   <= 1'b1;
      sym_len_o <= '0;
      early_o   <= 1'b0;
      late_o    <= 1'b0;
    end else begin
      early_o <= 1'b0;
      late_o  <= 1'b0;
      if (clear) begin
        cnt     <= '0;
        first_q <= 1'b1;
      end else if (wrap) begin
        cnt       <= '0;
        first_q   <= 1'b0;
        sym_len_o <= len;
        if (!first_q) begin
          early_o <= (len < OSF_LEN);
          late_o  <= (len > OSF_LEN);
        end
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + SLEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/timing_nco.sv
// Symbol-timing NCO: fractional phase accumulator steered by a clamped
// timing-correction word, emitting one strobe per symbol.
module timing_nco
  import msk_timing_pkg::*;
#(
  parameter int OSF        = 20,
  parameter int CTRL_W     = 18,
  parameter int INT_W      = 5,
  parameter int FRAC_W     = 27,
  parameter int CTRL_SHIFT = 15,
  parameter int CTRL_LIM   = 2048,
  localparam int PHASE_W   = phase_width(INT_W, FRAC_W),
  localparam int SLEN_W    = slen_width(OSF)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en_i,
  input  logic                     resync_i,
  input  logic signed [CTRL_W-1:0] ctrl_i,
  input  logic                     ctrl_val_i,
  output logic                     sym_valid_o,
  output logic [INT_W-1:0]         phase_int_o,
  output logic [FRAC_W-1:0]        mu_o,
  output logic [SLEN_W-1:0]        sym_len_o,
  output logic                     early_o,
  output logic                     late_o,
  output logic                     clamp_o
);

  localparam int STEP_W = PHASE_W + 2;
  localparam logic signed [STEP_W-1:0] ONE_SAMPLE = STEP_W'(1) << FRAC_W;
  localparam logic signed [STEP_W-1:0] OSF_PHASE  = STEP_W'(OSF) << FRAC_W;
  localparam logic signed [CTRL_W-1:0] LIM_POS    = CTRL_W'(CTRL_LIM);
  localparam logic signed [CTRL_W-1:0] LIM_NEG    = -LIM_POS;

  if (OSF >= 2 ** INT_W) begin : g_osf_check
    $error("timing_nco: OSF does not fit in INT_W integer phase bits");
  end

  if ((longint'(CTRL_LIM) << CTRL_SHIFT) >= (longint'(1) << FRAC_W)) begin : g_lim_check
    $error("timing_nco: CTRL_LIM << CTRL_SHIFT must stay below one sample");
  end

  nco_state_t                state, state_next;
  logic signed [CTRL_W-1:0]  ctrl_q;
  logic        [PHASE_W-1:0] phi;
  logic signed [STEP_W-1:0]  step, phi_sum, phi_next;
  logic                      wrap, running, advance, clear;
  logic                      unused_phi_top;

  // Correction scaled to the phase LSB and added to a nominal one-sample step.
  assign step    = ONE_SAMPLE + ({{(STEP_W - CTRL_W){ctrl_q[CTRL_W-1]}}, ctrl_q} <<< CTRL_SHIFT);
  assign phi_sum = $signed({2'b00, phi}) + step;
  assign wrap    = (phi_sum >= OSF_PHASE);
  assign phi_next = wrap ? (phi_sum - OSF_PHASE) : phi_sum;
  assign unused_phi_top = ^phi_next[STEP_W-1:PHASE_W];

  assign running = (state == RUN) && en_i;
  assign advance = running && !resync_i;
  assign clear   = !running || resync_i;

  assign phase_int_o = phi[PHASE_W-1:FRAC_W];
  assign mu_o        = phi[FRAC_W-1:0];

  // Latch the saturated correction word and flag when saturation kicked in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      clamp_o <= 1'b0;
    end else begin
      clamp_o <= 1'b0;
      if (ctrl_val_i) begin
        if (ctrl_i > LIM_POS) begin
          ctrl_q  <= LIM_POS;
          clamp_o <= 1'b1;
        end else if (ctrl_i < LIM_NEG) begin
          ctrl_q  <= LIM_NEG;
          clamp_o <= 1'b1;
        end else begin
          ctrl_q <= ctrl_i;
        end
      end
    end
  end

  // Run/idle state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Enable alone moves the NCO between idle and running.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en_i)  state_next = RUN;
      RUN:     if (!en_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Advance the phase while running; resync and idle both pin it to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi         <= '0;
      sym_valid_o <= 1'b0;
    end else begin
      sym_valid_o <= advance && wrap;
      phi         <= advance ? phi_next[PHASE_W-1:0] : '0;
    end
  end

  timing_nco_slen #(
    .OSF    (OSF),
    .SLEN_W (SLEN_W)
  ) u_slen (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .wrap      (advance && wrap),
    .sym_len_o (sym_len_o),
    .early_o   (early_o),
    .late_o    (late_o)
  );

endmodule
